apu_pulse_regs: RTL and testbench
=================================

Name: apu_pulse_regs

Overview:
- CPU-side register front end for the two APU pulse channels. Decodes 6502 bus writes to $4000-$4007 and $4015.
- Holds the eight pulse registers and drives them to the square channels as r4000..r4007.
- Issues one-cycle side-effect strobes, owns both 8-bit length counters, and serves the $4015 status read.
- Sits between the CPU bus adapter and the two square channel instances.

Parameters:
- ADDR_W, 5, width of the register offset from $4000; covers offsets $00-$17.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  register offset from $4000
- cpu_wdata  in  8  write data
- cpu_we  in  1  write strobe; one write per asserted cycle
- cpu_re  in  1  read strobe
- cpu_rdata  out  8  read data, registered
- half_frame  in  1  one-cycle half-frame tick from the frame sequencer
- r4000, r4001, r4002, r4003  out  8 each  pulse 1 registers
- r4004, r4005, r4006, r4007  out  8 each  pulse 2 registers
- p1_restart, p2_restart  out  1  pulse on a write to $4003 / $4007
- p1_sweep_reload, p2_sweep_reload  out  1  pulse on a write to $4001 / $4005
- p1_active, p2_active  out  1  length counter nonzero

Behaviour:
- Reset:
  - All r400x = 8'h00; enable bits en1 = en2 = 0; both length counters = 0.
  - All strobes = 0; cpu_rdata = 8'h00.
- Writes, cpu_we=1:
  - Offsets $00-$07 store cpu_wdata into the matching register at the clock edge.
  - The new value is visible on r400x the following cycle.
  - Other offsets are ignored, except $15.
- Strobes:
  - p1_restart / p2_restart and p1_sweep_reload / p2_sweep_reload are registered.
  - Each is high exactly one cycle, the cycle after the triggering write, coincident with the new register value.
  - Back-to-back writes give back-to-back pulses.
- Length load:
  - Applies on a write to $03 (pulse 1) or $07 (pulse 2) when that channel's enable bit is 1.
  - len <= LEN_TABLE[cpu_wdata[7:3]].
  - If the channel is disabled, the register is still stored and restart still pulses, but the length is not loaded.
- $4015 write:
  - en1 = cpu_wdata[0], en2 = cpu_wdata[1].
  - Clearing an enable forces that channel's length to 0 in the same edge.
- Length decrement:
  - On half_frame=1, each length counter decrements when len != 0 and its halt bit is 0.
  - Halt bits: r4000[5] for pulse 1, r4004[5] for pulse 2. Never wraps below 0.
- Priority per channel, highest first:
  1. enable clear
  2. length load
  3. half_frame decrement
- Halt bit timing: a halt bit written in the same cycle as half_frame takes effect from the next tick; the decrement uses the old register value.
- p1_active = (len1 != 0); p2_active = (len2 != 0). Combinational from the length registers.
- Reads:
  - cpu_re=1 at $15 gives cpu_rdata = {6'b0, p2_active, p1_active} one cycle later (see the optional feature).
  - Any other read gives 8'h00.
  - cpu_rdata holds its value until the next read.
  - Reads have no side effects.
- Simultaneous cpu_we and cpu_re: the write is performed; the read returns pre-write status.
- Reset mid-operation: synchronous rst overrides every write, tick and strobe in that cycle.

Optional Feature:
- APU_STATUS_READ_EN
- Defined: the $4015 read path is as described above.
- Undefined: cpu_rdata is tied to 8'h00, cpu_re is ignored, and no read register is inferred. Write-side $4015 behaviour is unchanged.

Decomposition:
- Package apu_pkg holds:
  - LEN_TABLE[0:31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30
  - Offset constants A_4000..A_4007 and A_4015.
- Sub-module apu_length_ctr, instantiated twice. Inputs: clk, rst, en, load, load_idx[4:0], halt, half_frame. Output: 8-bit len.

Test Plan:
- Reset, then write $15 = 8'h03 and $03 = 8'hF8 (index 31) -> len1 = 30, p1_active = 1, p1_restart high for exactly 1 cycle.
- en1 = 0, write $03 = 8'h08 (index 1) -> r4003 = 8'h08, p1_restart pulses, len1 stays 0, p1_active = 0.
- en1 = 1, $03 = 8'h18 (index 3, len 2), r4000[5] = 0, then two half_frame ticks -> len1 = 1, then 0; a third tick keeps 0, no wrap.
- Same as above but r4000 = 8'h20 (halt) -> len1 holds 2 across 5 ticks; set halt bit to 0 -> next tick gives 1.
- len2 = 254 (write $07 = 8'h08), then write $15 = 8'h01 coincident with half_frame -> len2 = 0 next cycle; with APU_STATUS_READ_EN, read $15 -> 8'h01 (p1 only active).
- Write $03 (index 1, len 254) coincident with half_frame -> len1 = 254 (load wins); assert rst mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/apu_pulse_regs_pkg.sv
// ---------------------------------------------------------------------------
// apu_pkg
// Shared constants for the APU pulse-channel register front end:
//   LEN_TABLE    - 32-entry length-counter load table, indexed by data[7:3]
//                  of a $4003/$4007 write
//   A_4000..A_4007, A_4015 - register offsets relative to $4000
// ---------------------------------------------------------------------------
package apu_pkg;

    localparam logic [7:0] LEN_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    localparam int unsigned A_4000 = 'h00;
    localparam int unsigned A_4001 = 'h01;
    localparam int unsigned A_4002 = 'h02;
    localparam int unsigned A_4003 = 'h03;
    localparam int unsigned A_4004 = 'h04;
    localparam int unsigned A_4005 = 'h05;
    localparam int unsigned A_4006 = 'h06;
    localparam int unsigned A_4007 = 'h07;
    localparam int unsigned A_4015 = 'h15;

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        return LEN_TABLE[idx];
    endfunction

endpackage

// File: rtl/apu_pulse_regs_if.sv
// ---------------------------------------------------------------------------
// apu_pulse_regs_if
// CPU-side register bus between the 6502 bus adapter and the pulse register
// front end.
//   cpu_addr  - register offset from $4000 (ADDR_W bits)
//   cpu_wdata - write data
//   cpu_we    - write strobe, one write per asserted cycle
//   cpu_re    - read strobe
//   cpu_rdata - registered read data
// modport master: bus adapter side; modport slave: register block side.
// ---------------------------------------------------------------------------
interface apu_pulse_regs_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [7:0]        cpu_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_rdata
    );
endinterface

// File: rtl/apu_pulse_regs_length_ctr.sv
// ---------------------------------------------------------------------------
// apu_length_ctr
// One pulse channel's 8-bit length counter.
//   clk, rst   - clock, synchronous active-high reset
//   en         - channel enable as it will be after this edge; low forces 0
//   load       - write to the channel's $4003/$4007 register this cycle
//   load_idx   - LEN_TABLE index (write data [7:3])
//   halt       - length halt bit (current register value)
//   half_frame - one-cycle half-frame tick
//   len        - counter value
// Priority: disable > load > half-frame decrement.
// ---------------------------------------------------------------------------
module apu_length_ctr
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [4:0] load_idx,
    input  logic       halt,
    input  logic       half_frame,
    output logic [7:0] len
);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            len <= 8'h00;
        end else if (!en) begin
            len <= 8'h00;
        end else if (load) begin
            len <= len_lookup(load_idx);
        end else if (half_frame && (len != 8'h00) && !halt) begin
            len <= len - 8'd1;
        end
    end

endmodule

// File: rtl/apu_pulse_regs.sv
// ---------------------------------------------------------------------------
// apu_pulse_regs
// CPU-side register front end for the two APU pulse channels. Decodes writes
// to $4000-$4007 and $4015, holds the eight pulse registers, issues one-cycle
// side-effect strobes, owns both length counters and serves the $4015 read.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   bus                   - CPU register bus (apu_pulse_regs_if.slave)
//   half_frame            - one-cycle half-frame tick from frame sequencer
//   r4000..r4003          - pulse 1 registers
//   r4004..r4007          - pulse 2 registers
//   p1/p2_restart         - one-cycle pulse after a write to $4003/$4007
//   p1/p2_sweep_reload    - one-cycle pulse after a write to $4001/$4005
//   p1/p2_active          - length counter nonzero
//
// Build option: APU_STATUS_READ_EN enables the registered $4015 status read.
// Without it cpu_rdata is tied to 8'h00 and cpu_re is ignored.
// ---------------------------------------------------------------------------
module apu_pulse_regs
    import apu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    apu_pulse_regs_if.slave        bus,
    input  logic                   half_frame,
    output logic [7:0]             r4000,
    output logic [7:0]             r4001,
    output logic [7:0]             r4002,
    output logic [7:0]             r4003,
    output logic [7:0]             r4004,
    output logic [7:0]             r4005,
    output logic [7:0]             r4006,
    output logic [7:0]             r4007,
    output logic                   p1_restart,
    output logic                   p2_restart,
    output logic                   p1_sweep_reload,
    output logic                   p2_sweep_reload,
    output logic                   p1_active,
    output logic                   p2_active
);

    logic [7:0] regs [8];
    logic       en1, en2;
    logic       en1_next, en2_next;
    logic [7:0] len1, len2;

    // Write decode
    logic wr_reg, wr_4001, wr_4003, wr_4005, wr_4007, wr_4015;

    assign wr_reg  = bus.cpu_we && (bus.cpu_addr < ADDR_W'(8));
    assign wr_4001 = bus.cpu_we && (bus.cpu_addr == ADDR_W'(A_4001));
    assign wr_4003 = bus.cpu_we && (bus.cpu_addr == ADDR_W'(A_4003));
    assign wr_4005 = bus.cpu_we && (bus.cpu_addr == ADDR_W'(A_4005));
    assign wr_4007 = bus.cpu_we && (bus.cpu_addr == ADDR_W'(A_4007));
    assign wr_4015 = bus.cpu_we && (bus.cpu_addr == ADDR_W'(A_4015));

    // NOTE: the eight-entry register file is reset explicitly; it is a
    // handful of flops feeding the channels, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (wr_reg) begin
            regs[bus.cpu_addr[2:0]] <= bus.cpu_wdata;
        end
    end

    assign r4000 = regs[A_4000];
    assign r4001 = regs[A_4001];
    assign r4002 = regs[A_4002];
    assign r4003 = regs[A_4003];
    assign r4004 = regs[A_4004];
    assign r4005 = regs[A_4005];
    assign r4006 = regs[A_4006];
    assign r4007 = regs[A_4007];

    // Side-effect strobes line up with the new register value.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_restart      <= 1'b0;
            p2_restart      <= 1'b0;
            p1_sweep_reload <= 1'b0;
            p2_sweep_reload <= 1'b0;
        end else begin
            p1_restart      <= wr_4003;
            p2_restart      <= wr_4007;
            p1_sweep_reload <= wr_4001;
            p2_sweep_reload <= wr_4005;
        end
    end

    // Enable bits. The counters see the post-write enable so that clearing
    // a channel zeroes its length on the same edge.
    assign en1_next = wr_4015 ? bus.cpu_wdata[0] : en1;
    assign en2_next = wr_4015 ? bus.cpu_wdata[1] : en2;

    always_ff @(posedge clk) begin
        if (rst) begin
            en1 <= 1'b0;
            en2 <= 1'b0;
        end else begin
            en1 <= en1_next;
            en2 <= en2_next;
        end
    end

    // Halt bits come from the current register contents, so a halt written
    // alongside a half-frame tick only affects later ticks.
    apu_length_ctr u_len1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en1_next),
        .load       (wr_4003),
        .load_idx   (bus.cpu_wdata[7:3]),
        .halt       (regs[A_4000][5]),
        .half_frame (half_frame),
        .len        (len1)
    );

    apu_length_ctr u_len2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en2_next),
        .load       (wr_4007),
        .load_idx   (bus.cpu_wdata[7:3]),
        .halt       (regs[A_4004][5]),
        .half_frame (half_frame),
        .len        (len2)
    );

    assign p1_active = (len1 != 8'h00);
    assign p2_active = (len2 != 8'h00);

`ifdef APU_STATUS_READ_EN
    // Status reflects pre-write lengths when a read and write coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cpu_rdata <= 8'h00;
        end else if (bus.cpu_re) begin
            bus.cpu_rdata <= (bus.cpu_addr == ADDR_W'(A_4015))
                           ? {6'b0, p2_active, p1_active} : 8'h00;
        end
    end
`else
    logic unused_re;
    assign unused_re     = bus.cpu_re;
    assign bus.cpu_rdata = 8'h00;
`endif

endmodule

// File: tb/tb_apu_pulse_regs.sv
// ---------------------------------------------------------------------------
// tb_apu_pulse_regs
// Self-checking bench for apu_pulse_regs: directed scenarios with literal
// expectations, then randomized traffic compared each cycle against a
// behavioural model of the register block.
// ---------------------------------------------------------------------------
module tb_apu_pulse_regs;

    localparam int TBL [32] = '{
        10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30
    };

    logic clk = 1'b0;
    logic rst;
    logic half_frame;
    logic [7:0] r4000, r4001, r4002, r4003, r4004, r4005, r4006, r4007;
    logic p1_restart, p2_restart, p1_sweep_reload, p2_sweep_reload;
    logic p1_active, p2_active;

    apu_pulse_regs_if #(.ADDR_W(5)) bus ();

    apu_pulse_regs #(.ADDR_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .half_frame      (half_frame),
        .r4000           (r4000),
        .r4001           (r4001),
        .r4002           (r4002),
        .r4003           (r4003),
        .r4004           (r4004),
        .r4005           (r4005),
        .r4006           (r4006),
        .r4007           (r4007),
        .p1_restart      (p1_restart),
        .p2_restart      (p2_restart),
        .p1_sweep_reload (p1_sweep_reload),
        .p2_sweep_reload (p2_sweep_reload),
        .p1_active       (p1_active),
        .p2_active       (p2_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [8];
    int         m_len  [2];
    bit         m_en   [2];
    bit         m_restart [2];
    bit         m_sweep   [2];
    int         m_rdata;
    bit         cmp_en = 1'b0;

    task automatic model_update(input logic [4:0] a, input logic [7:0] d,
                                input logic we, input logic re,
                                input logic hf, input logic r);
        bit halt [2];
        int nl;
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            for (int c = 0; c < 2; c++) begin
                m_len[c] = 0; m_en[c] = 0; m_restart[c] = 0; m_sweep[c] = 0;
            end
            m_rdata = 0;
            return;
        end
        halt[0] = m_regs[0][5];
        halt[1] = m_regs[4][5];
`ifdef APU_STATUS_READ_EN
        if (re) m_rdata = (a == 5'h15)
            ? ((m_len[1] != 0 ? 2 : 0) + (m_len[0] != 0 ? 1 : 0)) : 0;
`else
        m_rdata = 0;
`endif
        for (int c = 0; c < 2; c++) begin
            m_restart[c] = we && (a == 5'(3 + 4 * c));
            m_sweep[c]   = we && (a == 5'(1 + 4 * c));
            nl = m_len[c];
            if (hf && nl > 0 && !halt[c]) nl = nl - 1;
            if (we && a == 5'(3 + 4 * c) && m_en[c]) nl = TBL[d >> 3];
            if (we && a == 5'h15 && !d[c]) nl = 0;
            m_len[c] = nl;
        end
        if (we && a == 5'h15) begin
            m_en[0] = d[0];
            m_en[1] = d[1];
        end
        if (we && a < 5'd8) m_regs[a[2:0]] = d;
    endtask

    // Compare process: every negedge once the model has seen a reset.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("r4000", r4000, m_regs[0]);
            check("r4001", r4001, m_regs[1]);
            check("r4002", r4002, m_regs[2]);
            check("r4003", r4003, m_regs[3]);
            check("r4004", r4004, m_regs[4]);
            check("r4005", r4005, m_regs[5]);
            check("r4006", r4006, m_regs[6]);
            check("r4007", r4007, m_regs[7]);
            check("p1_restart", p1_restart, m_restart[0]);
            check("p2_restart", p2_restart, m_restart[1]);
            check("p1_sweep", p1_sweep_reload, m_sweep[0]);
            check("p2_sweep", p2_sweep_reload, m_sweep[1]);
            check("p1_active", p1_active, m_len[0] != 0);
            check("p2_active", p2_active, m_len[1] != 0);
            check("len1", dut.u_len1.len, m_len[0]);
            check("len2", dut.u_len2.len, m_len[1]);
            check("rdata", bus.cpu_rdata, m_rdata);
        end
    end

    // One clock cycle: drive at negedge, model advances at posedge.
    task automatic step(input logic [4:0] a, input logic [7:0] d,
                        input logic we, input logic re,
                        input logic hf, input logic r);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        half_frame    = hf;
        rst           = r;
        @(posedge clk);
        model_update(a, d, we, re, hf, r);
        @(negedge clk);
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        half_frame    = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic hf);
        step(a, d, 1'b1, 1'b0, hf, 1'b0);
    endtask

    task automatic idle(input logic hf);
        step(5'h00, 8'h00, 1'b0, 1'b0, hf, 1'b0);
    endtask

    int exp_status;

    initial begin
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
        half_frame = 1'b0; rst = 1'b1;
        @(negedge clk);
        step(5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp_en = 1'b1;

        // Reset state
        check("rst_r4003", r4003, 0);
        check("rst_active", {p2_active, p1_active}, 0);
        check("rst_rdata", bus.cpu_rdata, 0);

        // Enable both, load index 31 on pulse 1
        wr(5'h15, 8'h03, 1'b0);
        wr(5'h03, 8'hF8, 1'b0);
        check("t1_len1", dut.u_len1.len, 30);
        check("t1_active", p1_active, 1);
        check("t1_restart", p1_restart, 1);
        idle(1'b0);
        check("t1_restart_off", p1_restart, 0);

        // Disabled channel: register stored, restart pulses, no load
        wr(5'h15, 8'h02, 1'b0);
        check("t2_cleared", dut.u_len1.len, 0);
        wr(5'h03, 8'h08, 1'b0);
        check("t2_r4003", r4003, 8'h08);
        check("t2_restart", p1_restart, 1);
        check("t2_len1", dut.u_len1.len, 0);
        check("t2_active", p1_active, 0);

        // Decrement to zero, no wrap
        wr(5'h15, 8'h03, 1'b0);
        wr(5'h00, 8'h00, 1'b0);
        wr(5'h03, 8'h18, 1'b0);
        check("t3_load", dut.u_len1.len, 2);
        idle(1'b1);
        check("t3_tick1", dut.u_len1.len, 1);
        idle(1'b1);
        check("t3_tick2", dut.u_len1.len, 0);
        idle(1'b1);
        check("t3_nowrap", dut.u_len1.len, 0);

        // Halt holds the count; clearing halt resumes
        wr(5'h00, 8'h20, 1'b0);
        wr(5'h03, 8'h18, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("t4_halted", dut.u_len1.len, 2);
        wr(5'h00, 8'h00, 1'b1);   // halt cleared with tick: old halt applies
        check("t4_halt_timing", dut.u_len1.len, 2);
        idle(1'b1);
        check("t4_resume", dut.u_len1.len, 1);

        // Clear pulse 2 enable coincident with half_frame
        wr(5'h03, 8'hF8, 1'b0);
        wr(5'h07, 8'h08, 1'b0);
        check("t5_len2", dut.u_len2.len, 254);
        wr(5'h15, 8'h01, 1'b1);
        check("t5_len2_clr", dut.u_len2.len, 0);
        check("t5_len1_dec", dut.u_len1.len, 29);
        step(5'h15, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef APU_STATUS_READ_EN
        exp_status = 8'h01;
`else
        exp_status = 8'h00;
`endif
        check("t5_status", bus.cpu_rdata, exp_status);
        idle(1'b0);
        check("t5_hold", bus.cpu_rdata, exp_status);

        // Write and read together: read returns pre-write status
        step(5'h15, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_prewrite", bus.cpu_rdata, exp_status);
        check("t6_len1", dut.u_len1.len, 0);

        // Load beats half_frame; reset overrides everything
        wr(5'h15, 8'h03, 1'b0);
        wr(5'h03, 8'h08, 1'b1);
        check("t7_load_wins", dut.u_len1.len, 254);
        step(5'h07, 8'hF8, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t7_rst_len1", dut.u_len1.len, 0);
        check("t7_rst_r4003", r4003, 0);
        check("t7_rst_strobe", p2_restart, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a;
            logic [7:0] d;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 5'($urandom_range(0, 7));
            else if (sel < 9)  a = 5'h15;
            else               a = 5'($urandom_range(0, 31));
            d = 8'($urandom);
            if (a == 5'h15 && $urandom_range(0, 3) != 0) d[1:0] = 2'b11;
            step(a, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
        end

        idle(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
